// File: rtl/sm_mem_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM: round-robin between the
// CPU data port (m0) and a DMA/debug port (m1), with a bounded m0 lock for RMW.
module sm_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4,
  parameter int RR_INIT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData
);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);
  localparam master_e    RR_RESET = (RR_INIT != 0) ? M1 : M0;

  master_e    rr_ptr;
  logic [7:0] lock_cnt;
  logic       lock_active;
  logic [1:0] rd_owner;
  logic       lock_win;
  logic       any_gnt;

  // Grant decision. Reset suppresses every grant so the RAM sees no write.
  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    lock_win = 1'b0;
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (lock_active && (lock_cnt < LOCK_MAX)) begin
          m0_gnt   = 1'b1;
          lock_win = 1'b1;
        end else if (rr_ptr == M0) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign any_gnt = m0_gnt | m1_gnt;

  // RAM-side mux; an idle bus is driven to all zeros.
  always_comb begin
    memAddr  = '0;
    memWe    = 1'b0;
    memWData = '0;
    if (m0_gnt) begin
      memAddr  = m0_addr;
      memWe    = m0_we;
      memWData = m0_wdata;
    end else if (m1_gnt) begin
      memAddr  = m1_addr;
      memWe    = m1_we;
      memWData = m1_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= RR_RESET;
      lock_cnt    <= '0;
      lock_active <= 1'b0;
      rd_owner    <= '0;
    end else begin
      if (m0_gnt) begin
        rr_ptr <= M1;
      end else if (m1_gnt) begin
        rr_ptr <= M0;
      end

      lock_active <= m0_gnt & m0_lock;

      // Only contended locked wins advance the count; an uncontested lock holds it.
      if (m1_gnt || (m0_gnt && !m0_lock) || !any_gnt) begin
        lock_cnt <= '0;
      end else if (lock_win && (lock_cnt < LOCK_MAX)) begin
        lock_cnt <= lock_cnt + 8'd1;
      end

      rd_owner <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
    end
  end

  // Gating with rst drops a read whose return would land in a reset cycle.
  assign m0_rvalid = rd_owner[0] & ~rst;
  assign m1_rvalid = rd_owner[1] & ~rst;
  assign rdata     = memRData;

`ifndef SYNTHESIS
  a_one_gnt: assert property (@(posedge clk) !(m0_gnt && m1_gnt));
  a_one_rvalid: assert property (@(posedge clk) !(m0_rvalid && m1_rvalid));
`endif

endmodule

// File: doc/sm_mem_arbiter.md
Name: sm_mem_arbiter

Overview:
- Two-master arbiter that shares one single-port synchronous data RAM (1-cycle read latency) between the CPU data port (master 0) and a DMA/debug master (master 1).
- Round-robin arbitration with a master-0 lock for read-modify-write sequences; a counter bounds lock length so master 1 cannot starve.
- Registered read-owner tracking steers read-valid back to the master that issued the read.

Parameters:
- ADDR_W, 32, address width of masters and RAM.
- DATA_W, 32, data width.
- MAX_LOCK, 4, max consecutive locked grants to m0 while m1 waits (1..255).
- RR_INIT, 0, master that has priority for the first contention after reset (0 or 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- m0_req  input  1  master 0 request.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_lock  input  1  master 0 requests back-to-back ownership.
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_gnt  output  1  master 0 granted this cycle.
- m0_rvalid  output  1  read data for master 0 valid this cycle.
- m1_req, m1_we, m1_addr, m1_wdata  inputs  as for m0.
- m1_gnt, m1_rvalid  outputs  as for m0.
- rdata  output  DATA_W  read data, common to both masters, qualified by mN_rvalid.
- memAddr  output  ADDR_W  RAM address.
- memWe  output  1  RAM write enable.
- memWData  output  DATA_W  RAM write data.
- memRData  input  DATA_W  RAM read data, valid the cycle after the read address.

Behaviour:
- One clock, `clk`; reset `rst` is synchronous and active-high. All state updates on posedge clk.
- Grant is combinational from req and state: at most one of m0_gnt/m1_gnt is high per cycle. A transaction completes in its grant cycle. A requester holds req/we/addr/wdata stable until it sees gnt.
- Memory side: memAddr/memWe/memWData are muxed from the granted master. With no grant: memWe=0, memAddr=0, memWData=0.
- Arbitration, evaluated in this order:
  1. Only one master requests -> grant it.
  2. Both request, lock_active (previous cycle granted m0 with m0_lock=1) and lock_cnt < MAX_LOCK -> grant m0.
  3. Both request otherwise -> grant the master indicated by rr_ptr.
- State registers:
  - rr_ptr: after any grant, points to the other master. Reset value RR_INIT.
  - lock_cnt (8 bit): increments when m0 is granted by rule 2. Clears when m1 is granted, when m0 is granted with m0_lock=0, or when no grant occurs. Saturates at MAX_LOCK. Reset value 0.
  - lock_active: set when m0 is granted with m0_lock=1; otherwise cleared. Reset value 0.
- Lock with m1 idle: m0 may hold the bus indefinitely and lock_cnt does not advance. lock_cnt counts only contended cycles.
- Read return:
  - rd_owner (2 bit, one-hot per master) is registered: bit N = mN_gnt & ~mN_we.
  - mN_rvalid = rd_owner[N], exactly 1 cycle after the read grant.
  - rdata = memRData, passed through combinationally.
  - Writes produce no rvalid.
- Back-to-back operations: a read from one master followed by a grant to the other in the next cycle is legal. The rvalid of the earlier read and the new grant coexist in the same cycle.
- Reset:
  - While rst=1: m0_gnt=m1_gnt=0, memWe=0.
  - The cycle after rst deasserts: m0_rvalid=m1_rvalid=0, rr_ptr=RR_INIT, lock_cnt=0, lock_active=0.
  - A read granted in the cycle before reset is asserted never returns rvalid (dropped). The requester must reissue it.
- Illegal inputs: a req that drops before gnt is ignored. m0_lock with m0_req=0 has no effect.

Test Plan:
- Single master: m0 read addr 0x10 (RAM holds 0xDEADBEEF), m1 idle -> m0_gnt same cycle, memAddr=0x10, memWe=0; next cycle m0_rvalid=1, rdata=0xDEADBEEF, m1_rvalid=0.
- Round-robin: RR_INIT=0, both request reads continuously with no lock -> grants alternate m0,m1,m0,m1; each rvalid follows its grant by exactly 1 cycle.
- Lock bound: MAX_LOCK=4, m0_lock=1, both requesting every cycle -> first m0 grant by rr_ptr, then 4 locked m0 grants, then m1_gnt=1; lock_cnt clears to 0 when m1 is granted.
- Write path: m1 writes 0x1234 to addr 0x20 while m0 is idle -> memWe=1, memWData=0x1234, memAddr=0x20 for one cycle; no rvalid; a following m0 read of 0x20 returns 0x1234.
- Reset mid-read: m1 read granted in cycle N, rst=1 in cycle N+1 -> m1_rvalid=0 in N+1 and N+2; after release, first contention grants RR_INIT.
- Simultaneous events: m0 read granted in cycle N, m1 write granted in N+1 -> in N+1, m0_rvalid=1 and memWe=1 together, with memAddr equal to m1_addr.
